// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 scan-code constants, FIFO entry layout and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] c_PFX_E0     = 8'hE0;
    localparam logic [7:0] c_PFX_F0     = 8'hF0;
    localparam logic [7:0] c_PFX_E1     = 8'hE1;
    localparam logic [7:0] c_FAKE_SHIFT = 8'h12;

    localparam int c_ENTRY_W     = 11;
    localparam int c_BIT_SPECIAL = 10;
    localparam int c_BIT_BREAK   = 9;
    localparam int c_BIT_EXT     = 8;

    // Pause/Break sends E1 followed by seven more bytes that carry no key data.
    localparam logic [2:0] c_PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_E0    = 3'd1,
        S_F0    = 3'd2,
        S_E0F0  = 3'd3,
        S_PAUSE = 3'd4
    } ps2_state_t;

    function automatic logic is_special(input logic [7:0] code);
        case (code)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [c_ENTRY_W-1:0] make_entry(
        input logic       sp,
        input logic       brk,
        input logic       ext,
        input logic [7:0] code
    );
        logic [c_ENTRY_W-1:0] e;
        e                = '0;
        e[7:0]           = code;
        e[c_BIT_EXT]     = ext;
        e[c_BIT_BREAK]   = brk;
        e[c_BIT_SPECIAL] = sp;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through FIFO with sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic                     i_ovf_clr,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_ovf;

    logic w_full;
    logic w_do_rd;
    logic w_do_wr;
    logic w_overflow;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_do_rd    = i_rd_en && (r_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_do_wr    = i_wr_en && (!w_full || w_do_rd);
    assign w_overflow = i_wr_en && w_full && !w_do_rd;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_decoder
// Description : PS/2 set-2 scan-code decoder with prefix timeout and event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int DEPTH             = 8,
    parameter int PREFIX_TIMEOUT_US = 2000
) (
    input  logic                     clk6x,
    input  logic                     resetn,
    input  logic                     ck1us,
    input  logic [7:0]               code_rx_i,
    input  logic                     code_rx_v_i,
    input  logic                     rd_en_i,
    output logic [c_ENTRY_W-1:0]     rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o,
    input  logic                     ovf_clr_i
);

    localparam int             TW         = $clog2(PREFIX_TIMEOUT_US + 1);
    localparam logic [TW-1:0]  c_TMR_LOAD = TW'(PREFIX_TIMEOUT_US);

    ps2_state_t           r_state;
    ps2_state_t           w_state_nxt;
    logic [TW-1:0]        r_timer;
    logic [TW-1:0]        w_timer_nxt;
    logic [2:0]           r_skip;
    logic [2:0]           w_skip_nxt;
    logic                 w_push;
    logic [c_ENTRY_W-1:0] w_push_data;

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_skip_nxt  = r_skip;
        w_push      = 1'b0;
        w_push_data = '0;
        if (code_rx_v_i) begin
            // Any byte that leaves a prefix state clears the timer; staying reloads it.
            w_timer_nxt = '0;
            case (r_state)
                S_IDLE: begin
                    if (code_rx_i == c_PFX_E0) begin
                        w_state_nxt = S_E0;
                        w_timer_nxt = c_TMR_LOAD;
                    end else if (code_rx_i == c_PFX_F0) begin
                        w_state_nxt = S_F0;
                        w_timer_nxt = c_TMR_LOAD;
                    end else if (code_rx_i == c_PFX_E1) begin
                        w_state_nxt = S_PAUSE;
                        w_timer_nxt = c_TMR_LOAD;
                        w_skip_nxt  = c_PAUSE_SKIP;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = make_entry(is_special(code_rx_i), 1'b0, 1'b0, code_rx_i);
                    end
                end
                S_E0: begin
                    if (code_rx_i == c_PFX_F0) begin
                        w_state_nxt = S_E0F0;
                        w_timer_nxt = c_TMR_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_push      = (code_rx_i != c_FAKE_SHIFT);
                        w_push_data = make_entry(1'b0, 1'b0, 1'b1, code_rx_i);
                    end
                end
                S_F0: begin
                    w_state_nxt = S_IDLE;
                    w_push      = 1'b1;
                    w_push_data = make_entry(1'b0, 1'b1, 1'b0, code_rx_i);
                end
                S_E0F0: begin
                    w_state_nxt = S_IDLE;
                    w_push      = (code_rx_i != c_FAKE_SHIFT);
                    w_push_data = make_entry(1'b0, 1'b1, 1'b1, code_rx_i);
                end
                S_PAUSE: begin
                    if (r_skip <= 3'd1) begin
                        w_state_nxt = S_IDLE;
                        w_skip_nxt  = '0;
                        w_push      = 1'b1;
                        w_push_data = make_entry(1'b0, 1'b0, 1'b0, c_PFX_E1);
                    end else begin
                        w_skip_nxt  = r_skip - 3'd1;
                        w_timer_nxt = c_TMR_LOAD;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_skip_nxt  = '0;
                end
            endcase
        end else if ((r_state != S_IDLE) && ck1us) begin
            if (r_timer <= TW'(1)) begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
                w_skip_nxt  = '0;
            end else begin
                w_timer_nxt = r_timer - TW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk6x),
        .rst_n     (resetn),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (rd_en_i),
        .i_ovf_clr (ovf_clr_i),
        .o_rd_data (rd_data_o),
        .o_empty   (empty_o),
        .o_count   (count_o),
        .o_ovf     (ovf_o)
    );

endmodule
`default_nettype wire
